// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: register-index width, divide FSM encodings and shared helpers
package hazard_ctrl_pkg;
  localparam int RFIDX_WIDTH = 5;
  localparam int DIV_CYCLES_DEF = 32;
  typedef enum logic [1:0] {DIV_IDLE = 2'd0, DIV_BUSY = 2'd1, DIV_DONE = 2'd2} div_state_e;
  function automatic logic src_hit(input logic [RFIDX_WIDTH-1:0] rd, input logic [RFIDX_WIDTH-1:0] rs);
    return rd != '0 && rd == rs;
  endfunction
endpackage

// File: rtl/hazard_ctrl_div_timer.sv
// div_timer: sequences the multi-cycle divide stall window and the result-valid pulse
module div_timer
  import hazard_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic divE,
  output logic divstall,
  output logic divvalidE
);
  div_state_e r_state;
  logic [7:0] r_cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= DIV_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        DIV_IDLE: if (divE) begin
          r_state <= DIV_BUSY;
          r_cnt   <= 8'(DIV_CYCLES - 1);
        end
        DIV_BUSY: if (r_cnt == 8'd0) r_state <= DIV_DONE;
                  else r_cnt <= r_cnt - 8'd1;
        default: r_state <= DIV_IDLE;
      endcase
    end
  end
  // DONE never restarts on divE, so a following divide waits one cycle for IDLE
  assign divstall  = !reset && ((r_state == DIV_IDLE && divE) || r_state == DIV_BUSY);
  assign divvalidE = !reset && r_state == DIV_DONE;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, redirect flush and divide hold for the five-stage pipeline
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [RFIDX_WIDTH-1:0] rs1D,
  input  logic [RFIDX_WIDTH-1:0] rs2D,
  input  logic [RFIDX_WIDTH-1:0] rdE,
  input  logic                   memtoregE,
  input  logic                   pcsrcE,
  input  logic                   divE,
  output logic                   stallF,
  output logic                   stallD,
  output logic                   stallE,
  output logic                   flushD,
  output logic                   flushE,
  output logic                   flushM,
  output logic                   divvalidE
);
  logic w_divstall, w_lwstall, w_run;
  div_timer #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk      (clk),
    .reset    (reset),
    .divE     (divE),
    .divstall (w_divstall),
    .divvalidE(divvalidE)
  );
  assign w_lwstall = memtoregE && (src_hit(rdE, rs1D) || src_hit(rdE, rs2D));
  assign w_run     = !reset && !w_divstall;
  // a redirect kills the wrong-path D instruction, so its load-use stall is moot
  assign stallF = w_divstall || (w_run && !pcsrcE && w_lwstall);
  assign stallD = stallF;
  assign stallE = w_divstall;
  assign flushD = w_run && pcsrcE;
  assign flushE = w_run && (pcsrcE || w_lwstall);
  assign flushM = w_divstall;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of hazard_ctrl with divide latencies 4, 1, 32 and 255
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic reset, memtoregE, pcsrcE, divE;
  logic [4:0] rs1D, rs2D, rdE;
  logic [3:0][6:0] o;
  int total = 0;
  int bad = 0;
  localparam logic [6:0] S = 7'b1110010;
  localparam logic [6:0] D = 7'b0000001;
  localparam logic [6:0] L = 7'b1100100;
  localparam logic [6:0] R = 7'b0001100;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    hazard_ctrl #(.DIV_CYCLES(g == 0 ? 4 : g == 1 ? 1 : g == 2 ? 32 : 255)) dut (
      .clk      (clk),
      .reset    (reset),
      .rs1D     (rs1D),
      .rs2D     (rs2D),
      .rdE      (rdE),
      .memtoregE(memtoregE),
      .pcsrcE   (pcsrcE),
      .divE     (divE),
      .stallF   (o[g][6]),
      .stallD   (o[g][5]),
      .stallE   (o[g][4]),
      .flushD   (o[g][3]),
      .flushE   (o[g][2]),
      .flushM   (o[g][1]),
      .divvalidE(o[g][0])
    );
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drv(input logic m, input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                     input logic pc, input logic dv);
    memtoregE = m; rdE = rd; rs1D = r1; rs2D = r2; pcsrcE = pc; divE = dv;
  endtask
  task automatic step(input string tag, input logic [6:0] exp);
    #2;
    chk(tag, 32'(o[0]), 32'(exp));
    @(posedge clk);
    #1;
  endtask
  initial begin
    int n[4];
    bit seen[4];
    int lens[4];
    lens = '{5, 2, 33, 256};
    reset = 1'b1;
    drv(1, 5, 5, 0, 1, 1);
    step("rst_force", 0);
    reset = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    step("idle", 0);
    drv(1, 5, 5, 0, 0, 0);
    step("lw_rs1", L);
    drv(0, 5, 5, 0, 0, 0);
    step("no_load", 0);
    drv(1, 0, 0, 0, 0, 0);
    step("lw_rd0", 0);
    drv(1, 3, 0, 3, 0, 0);
    step("lw_rs2", L);
    drv(1, 3, 0, 0, 0, 0);
    step("lw_nomatch", 0);
    drv(1, 7, 0, 7, 1, 0);
    step("redirect_lw", R);
    drv(0, 0, 0, 0, 1, 0);
    step("redirect", R);
    drv(0, 0, 0, 0, 0, 1);
    repeat (5) step("div_stall", S);
    step("div_done", D);
    repeat (4) step("div2_stall", S);
    drv(1, 5, 5, 0, 1, 1);
    step("div2_ignore", S);
    drv(0, 0, 0, 0, 0, 1);
    step("div2_done", D);
    drv(0, 0, 0, 0, 0, 0);
    step("post_div", 0);
    drv(0, 0, 0, 0, 0, 1);
    step("rd_t0", S);
    step("rd_t1", S);
    reset = 1'b1;
    step("rd_rst", 0);
    reset = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    step("rd_idle", 0);
    step("rd_nopulse", 0);
    drv(0, 0, 0, 0, 0, 1);
    repeat (5) step("rd_restall", S);
    drv(0, 0, 0, 0, 0, 0);
    step("rd_done", D);
    step("rd_after", 0);
    reset = 1'b1;
    step("sw_rst", 0);
    reset = 1'b0;
    drv(0, 0, 0, 0, 0, 1);
    n = '{0, 0, 0, 0};
    seen = '{0, 0, 0, 0};
    for (int c = 0; c < 300; c++) begin
      #2;
      for (int k = 0; k < 4; k++)
        if (!seen[k]) begin
          if (o[k][0]) seen[k] = 1'b1;
          else if (o[k][4]) n[k]++;
        end
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("sweep_seen%0d", k), 32'(seen[k]), 32'd1);
      chk($sformatf("sweep_len%0d", k), n[k], lens[k]);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and control unit for the five-stage xgriscv core. It sits beside the ID/EX boundary, upstream of the EX-stage forwarding logic, and resolves the hazards that forwarding cannot. It stalls F/D on load-use dependences and flushes D/E on taken branches and jumps. It also holds F/D/E for the duration of a multi-cycle divide in EX, bubbling M and flagging the divide result valid on its final cycle.

## Interface
Parameters:
- `DIV_CYCLES`, default 32: iterative divider latency in cycles; legal range 1..255.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rs1D`  in  `RFIDX_WIDTH`  source register 1 of the instruction in D.
- `rs2D`  in  `RFIDX_WIDTH`  source register 2 of the instruction in D.
- `rdE`  in  `RFIDX_WIDTH`  destination register of the instruction in E.
- `memtoregE`  in  1  the E instruction is a load.
- `pcsrcE`  in  1  the E instruction redirects the PC (taken branch or jump).
- `divE`  in  1  the E instruction is div/divu/rem/remu.
- `stallF`  out  1  hold the PC.
- `stallD`  out  1  hold the IF/ID register.
- `stallE`  out  1  hold the ID/EX register.
- `flushD`  out  1  clear IF/ID to a nop.
- `flushE`  out  1  clear ID/EX to a nop.
- `flushM`  out  1  clear EX/MEM to a nop.
- `divvalidE`  out  1  the divider result in E is valid this cycle.

## Operation
- `lwstall` = `memtoregE && rdE!=0 && (rdE==rs1D || rdE==rs2D)`, where a zero rs1D or rs2D never matches.
- Divide FSM states:
  - IDLE: if `divE`, go to BUSY and load `cnt <= DIV_CYCLES-1`.
  - BUSY: `cnt` decrements each cycle. When `cnt==0`, go to DONE.
  - DONE: go to IDLE unconditionally. `divE` remaining high in DONE must not restart the divider.
- `divstall` = `(IDLE && divE) || BUSY`.
- While `divstall` is high:
  - `stallF`, `stallD` and `stallE` are 1.
  - `flushM` is 1.
  - `flushD` and `flushE` are 0.
  - `lwstall` and `pcsrcE` are ignored. Both cannot coexist with `divE`, since E holds a single instruction.
- When `pcsrcE` is high (and `divstall` is low): `flushD`=1, `flushE`=1, and `stallF`/`stallD` are 0. A redirect overrides a `lwstall` computed from the wrong-path D instruction.
- When `lwstall` is high (and neither case above applies): `stallF`=1, `stallD`=1, `flushE`=1.
- `divvalidE` = 1 in DONE only.
- All outputs are combinational from the FSM state and the inputs. `cnt` is 8 bits wide, and its width is fixed by the `DIV_CYCLES` range.
- While `reset` is high, every output is forced to 0. The FSM enters IDLE and `cnt` is cleared to 0 on the next edge.
- Reset during BUSY or DONE aborts the divide, and `divvalidE` does not pulse for the aborted operation.

## Timing
- Load-use:
  - Exactly one bubble per dependence.
  - The stall and flush take effect in the same cycle the hazard is visible.
  - The next cycle, the load is in M and the forwarding unit supplies the operand.
- Redirect: 2 wrong-path instructions are killed, with flushes in the same cycle `pcsrcE` is high.
- Divide:
  - The instruction enters E at cycle t with FSM in IDLE.
  - `divstall` is high for cycles t through t+`DIV_CYCLES`, which is `DIV_CYCLES`+1 cycles.
  - At t+`DIV_CYCLES`+1 the FSM is in DONE: `divvalidE`=1, all stalls are 0, and the divide advances to M on the following edge.
- Back-to-back divides: the second divide arrives in E the cycle after DONE, finds the FSM in IDLE, and starts a fresh sequence with no extra gap.
- `DIV_CYCLES`=1: IDLE(stall) → BUSY(cnt=0, stall) → DONE.

## Structure
- `RFIDX_WIDTH`, the FSM state encodings (`DIV_IDLE`=2'd0, `DIV_BUSY`=2'd1, `DIV_DONE`=2'd2) and the default `DIV_CYCLES` belong in `xgriscv_defines.v`.
- One sub-module, `div_timer`: it holds the FSM and `cnt`, takes `clk`, `reset` and `divE`, and outputs `divstall` and `divvalidE`.
- The top module `hazard_ctrl` contains the combinational load-use detection and the priority merge.

## Test plan
- Load-use: `memtoregE`=1, `rdE`=5, `rs1D`=5 → `stallF`=`stallD`=`flushE`=1 for one cycle. Repeat with `rdE`=0 and `rs1D`=0 → all outputs 0.
- Redirect priority: `pcsrcE`=1, `memtoregE`=1, `rdE`=7, `rs2D`=7 → `flushD`=`flushE`=1 and `stallF`=`stallD`=0.
- Divide with `DIV_CYCLES`=4: `divE` held high → stalls and `flushM` high for exactly 5 cycles, then `divvalidE`=1 for 1 cycle with stalls 0.
- Back-to-back divides: `divE` high across two consecutive divide instructions → two 5-cycle stall windows separated by exactly one DONE cycle.
- Reset mid-divide: assert `reset` at cycle t+2 → outputs 0 during reset. After release with `divE`=0, the FSM is in IDLE, no `divvalidE` pulse occurs, and the next `divE` produces the full 5-cycle stall.
- Sweep `DIV_CYCLES` ∈ {1, 32, 255} → stall length is `DIV_CYCLES`+1 in each case, and `cnt` never underflows.
